// File: rtl/noncoh_acc_ctrl.sv
// noncoh_acc_ctrl -- sequences one noncoherent accumulation pass over a set of bins.
//
// A pass reads each bin's coherent result (1-cycle RAM), reads the stored noncoherent
// sum two cycles later (1-cycle RAM, skipped on a first pass where nc_zero forces the
// operand to 0), samples the datapath overflow flag, and writes the new sum back.
// Overflow seen during a pass arms a halving (extra_shift) for the next pass and
// bumps the running halving count (nc_scale).
//
// Ports
//   clk, rst_b               clock, synchronous active-low reset
//   start, first_pass,       pass request and its parameters (sampled in IDLE only)
//   bin_num[10:0]
//   abort                    kill the current pass, back to IDLE
//   exceed                   datapath overflow, valid the cycle before the sum latches
//   coh_rd_en/coh_rd_addr    coherent RAM read
//   coh_valid                coherent data valid to datapath
//   nc_rd_en/nc_rd_addr      noncoherent RAM read
//   nc_zero                  zero the noncoherent operand (first pass)
//   nc_wr_en/nc_wr_addr      write-back of the latched sum
//   extra_shift, nc_scale    halving control and applied-halving count
//   busy, done               pass in progress / one-cycle completion pulse
module noncoh_acc_ctrl (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic        abort,
  input  logic        first_pass,
  input  logic [10:0] bin_num,
  input  logic        exceed,
  output logic        coh_rd_en,
  output logic [9:0]  coh_rd_addr,
  output logic        coh_valid,
  output logic        nc_rd_en,
  output logic [9:0]  nc_rd_addr,
  output logic        nc_zero,
  output logic        nc_wr_en,
  output logic [9:0]  nc_wr_addr,
  output logic        extra_shift,
  output logic [3:0]  nc_scale,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t     state;
  logic [9:0] last_addr;
  logic [9:0] p1_addr;
  logic       p2_valid;
  logic       p3_valid;
  logic [9:0] p3_addr;
  logic       first_q;
  logic       pass_exceed;

  // Pipeline: coh_rd (stage 0) -> coh_valid (1) -> nc_rd (2) -> exceed sample (3)
  // -> nc_wr (4). The stage-2 valid is kept separately from nc_rd_en because writes
  // still occur on a first pass even though the noncoherent read is suppressed.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state       <= IDLE;
      last_addr   <= '0;
      coh_rd_en   <= 1'b0;
      coh_rd_addr <= '0;
      coh_valid   <= 1'b0;
      p1_addr     <= '0;
      p2_valid    <= 1'b0;
      nc_rd_en    <= 1'b0;
      nc_rd_addr  <= '0;
      p3_valid    <= 1'b0;
      p3_addr     <= '0;
      nc_wr_en    <= 1'b0;
      nc_wr_addr  <= '0;
      nc_zero     <= 1'b0;
      first_q     <= 1'b0;
      pass_exceed <= 1'b0;
      extra_shift <= 1'b0;
      nc_scale    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      // Flags keep their values; only the in-flight pass is discarded.
      state       <= IDLE;
      coh_rd_en   <= 1'b0;
      coh_valid   <= 1'b0;
      p2_valid    <= 1'b0;
      nc_rd_en    <= 1'b0;
      p3_valid    <= 1'b0;
      nc_wr_en    <= 1'b0;
      nc_zero     <= 1'b0;
      pass_exceed <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      coh_valid  <= coh_rd_en;
      p1_addr    <= coh_rd_addr;
      p2_valid   <= coh_valid;
      nc_rd_en   <= coh_valid & ~first_q;
      nc_rd_addr <= p1_addr;
      p3_valid   <= p2_valid;
      p3_addr    <= nc_rd_addr;
      nc_wr_en   <= p3_valid;
      nc_wr_addr <= p3_addr;
      if (p3_valid && exceed) pass_exceed <= 1'b1;
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (bin_num == 11'd0) begin
              // Empty pass: report completion without touching RAM or flags.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= RUN;
              busy        <= 1'b1;
              coh_rd_en   <= 1'b1;
              coh_rd_addr <= '0;
              last_addr   <= (bin_num >= 11'd1024) ? 10'd1023 : (bin_num[9:0] - 10'd1);
              first_q     <= first_pass;
              nc_zero     <= first_pass;
              pass_exceed <= 1'b0;
              if (first_pass) begin
                extra_shift <= 1'b0;
                nc_scale    <= '0;
              end
            end
          end
        end
        RUN: begin
          // Stop on the last address rather than on wrap, so 1024 bins never roll over.
          if (coh_rd_addr == last_addr) begin
            coh_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            coh_rd_addr <= coh_rd_addr + 10'd1;
          end
        end
        DRAIN: begin
          // Only the final write remains in stage 4; every exceed has been sampled.
          if (!(coh_valid || p2_valid || p3_valid)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            nc_zero     <= 1'b0;
            extra_shift <= pass_exceed;
            if (pass_exceed && (nc_scale != 4'd15)) nc_scale <= nc_scale + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noncoh_acc_ctrl.sv
// Directed bench for noncoh_acc_ctrl: each pass pushes the expected strobes (cycle,
// address, side signals) into per-output queues; a negedge monitor pops and compares
// whenever the DUT asserts a strobe.
module tb_noncoh_acc_ctrl;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic        abort;
  logic        first_pass;
  logic [10:0] bin_num;
  logic        exceed;
  logic        coh_rd_en;
  logic [9:0]  coh_rd_addr;
  logic        coh_valid;
  logic        nc_rd_en;
  logic [9:0]  nc_rd_addr;
  logic        nc_zero;
  logic        nc_wr_en;
  logic [9:0]  nc_wr_addr;
  logic        extra_shift;
  logic [3:0]  nc_scale;
  logic        busy;
  logic        done;

  noncoh_acc_ctrl dut (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort), .first_pass(first_pass),
    .bin_num(bin_num), .exceed(exceed), .coh_rd_en(coh_rd_en), .coh_rd_addr(coh_rd_addr),
    .coh_valid(coh_valid), .nc_rd_en(nc_rd_en), .nc_rd_addr(nc_rd_addr), .nc_zero(nc_zero),
    .nc_wr_en(nc_wr_en), .nc_wr_addr(nc_wr_addr), .extra_shift(extra_shift),
    .nc_scale(nc_scale), .busy(busy), .done(done)
  );

  typedef struct {
    int c;
    int a;
    int b;
    int s;
  } ev_t;

  ev_t coh_q[$];
  ev_t cv_q[$];
  ev_t ncr_q[$];
  ev_t ncw_q[$];
  ev_t dn_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_es = 0;
  int exp_sc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input int sid, input int a, input int b, input int s, input string nm);
    ev_t e;
    bit  found;
    found = 1'b0;
    e = '{c: 0, a: 0, b: 0, s: 0};
    case (sid)
      0: if (coh_q.size() > 0) begin e = coh_q.pop_front(); found = 1'b1; end
      1: if (cv_q.size() > 0)  begin e = cv_q.pop_front();  found = 1'b1; end
      2: if (ncr_q.size() > 0) begin e = ncr_q.pop_front(); found = 1'b1; end
      3: if (ncw_q.size() > 0) begin e = ncw_q.pop_front(); found = 1'b1; end
      default: if (dn_q.size() > 0) begin e = dn_q.pop_front(); found = 1'b1; end
    endcase
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL %s: unexpected strobe at cycle %0d (a=%0d b=%0d s=%0d)", nm, cyc, a, b, s);
    end else if (e.c != cyc || e.a != a || e.b != b || e.s != s) begin
      n_err++;
      $display("FAIL %s: got cycle=%0d a=%0d b=%0d s=%0d, expected cycle=%0d a=%0d b=%0d s=%0d",
               nm, cyc, a, b, s, e.c, e.a, e.b, e.s);
    end
  endfunction

  // coh: a=addr b=nc_zero s=busy; cv: s=busy; ncr/ncw: a=addr s=busy; done: a=busy b=extra_shift s=nc_scale
  always @(negedge clk) begin
    if (coh_rd_en === 1'b1) chk(0, int'(coh_rd_addr), int'(nc_zero), int'(busy), "coh_rd");
    if (coh_valid === 1'b1) chk(1, 0, 0, int'(busy), "coh_valid");
    if (nc_rd_en === 1'b1)  chk(2, int'(nc_rd_addr), int'(nc_zero), int'(busy), "nc_rd");
    if (nc_wr_en === 1'b1)  chk(3, int'(nc_wr_addr), 0, int'(busy), "nc_wr");
    if (done === 1'b1)      chk(4, int'(busy), int'(extra_shift), int'(nc_scale), "done");
  end

  function automatic logic [41:0] all_outs();
    return {coh_rd_en, coh_rd_addr, coh_valid, nc_rd_en, nc_rd_addr, nc_zero, nc_wr_en,
            nc_wr_addr, extra_shift, nc_scale, busy, done};
  endfunction

  task automatic check_zero(input string nm);
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL %s: outputs=%h, expected all zero", nm, all_outs());
    end
  endtask

  task automatic check_flags(input string nm);
    n_cmp++;
    if (int'(extra_shift) != exp_es || int'(nc_scale) != exp_sc) begin
      n_err++;
      $display("FAIL %s: extra_shift=%0d nc_scale=%0d, expected extra_shift=%0d nc_scale=%0d",
               nm, extra_shift, nc_scale, exp_es, exp_sc);
    end
  endtask

  // kill_at: relative cycle during which abort (or reset) is held; -1 = none.
  // exc_k: bin whose exceed is asserted at relative cycle 4+k; -1 = none.
  task automatic run_pass(input bit first, input int n, input int exc_k, input bit spur,
                          input int kill_at, input bit kill_rst);
    int  c0;
    bit  pe;
    bit  killed;
    ev_t e;
    killed = (kill_at >= 0);
    @(negedge clk);
    c0 = cyc;
    start = 1'b1;
    first_pass = first;
    bin_num = 11'(n);
    if (n != 0 && first) begin
      exp_es = 0;
      exp_sc = 0;
    end
    for (int k = 0; k < n; k++) begin
      if (!killed || 1 + k <= kill_at) begin
        e = '{c: c0 + 1 + k, a: k, b: int'(first), s: 1}; coh_q.push_back(e);
      end
      if (!killed || 2 + k <= kill_at) begin
        e = '{c: c0 + 2 + k, a: 0, b: 0, s: 1}; cv_q.push_back(e);
      end
      if (!first && (!killed || 3 + k <= kill_at)) begin
        e = '{c: c0 + 3 + k, a: k, b: 0, s: 1}; ncr_q.push_back(e);
      end
      if (!killed || 5 + k <= kill_at) begin
        e = '{c: c0 + 5 + k, a: k, b: 0, s: 1}; ncw_q.push_back(e);
      end
    end
    if (!killed) begin
      if (n != 0) begin
        pe = (exc_k >= 0 && exc_k < n);
        exp_es = int'(pe);
        if (pe && exp_sc < 15) exp_sc++;
      end
      e = '{c: c0 + ((n == 0) ? 1 : n + 5), a: 0, b: exp_es, s: exp_sc};
      dn_q.push_back(e);
    end
    for (int j = 0; j < n + 7; j++) begin
      @(negedge clk);
      start   = spur && (cyc == c0 + 2);
      bin_num = (spur && cyc == c0 + 2) ? 11'd2 : 11'(n);
      exceed  = (exc_k >= 0) && (cyc == c0 + 4 + exc_k);
      abort   = killed && !kill_rst && (cyc == c0 + kill_at);
      if (killed && kill_rst) begin
        if (cyc == c0 + kill_at + 1) check_zero("midpass_reset_outputs");
        rst_b = !(cyc == c0 + kill_at || cyc == c0 + kill_at + 1);
      end
    end
    start = 1'b0;
    exceed = 1'b0;
    abort = 1'b0;
    rst_b = 1'b1;
    if (killed) begin
      if (kill_rst) begin
        exp_es = 0;
        exp_sc = 0;
      end
      check_flags(kill_rst ? "flags_after_reset" : "flags_after_abort");
    end
  endtask

  initial begin
    rst_b = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    first_pass = 1'b0;
    bin_num = '0;
    exceed = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    rst_b = 1'b1;
    @(negedge clk);

    run_pass(1'b1, 4, -1, 1'b0, -1, 1'b0);      // first pass, no overflow
    run_pass(1'b0, 3, 1, 1'b0, -1, 1'b0);       // exceed at cycle 5 -> shift armed, scale 1
    run_pass(1'b0, 3, -1, 1'b0, -1, 1'b0);      // clean pass -> shift off, scale held
    run_pass(1'b0, 8, -1, 1'b1, -1, 1'b0);      // start during busy ignored
    run_pass(1'b1, 0, -1, 1'b0, -1, 1'b0);      // empty pass: done at cycle 1, flags kept
    run_pass(1'b0, 2, 0, 1'b0, -1, 1'b0);       // arm shift, scale 2
    run_pass(1'b0, 8, 5, 1'b0, 3, 1'b0);        // abort at cycle 3

    // abort and start together in IDLE: nothing starts
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    bin_num = 11'd4;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_vs_start: busy=%b, expected 0", busy);
    end
    repeat (10) @(negedge clk);

    for (int i = 0; i < 16; i++) run_pass(1'b0, 2, 0, 1'b0, -1, 1'b0);  // saturate at 15
    run_pass(1'b1, 1, -1, 1'b0, -1, 1'b0);      // first pass clears flags
    run_pass(1'b0, 1024, 1023, 1'b0, -1, 1'b0); // full-size pass, overflow on last bin
    run_pass(1'b0, 8, -1, 1'b0, 3, 1'b1);       // reset mid-pass
    run_pass(1'b0, 2, -1, 1'b0, -1, 1'b0);      // recovers after reset

    repeat (4) @(negedge clk);
    n_cmp++;
    if (coh_q.size() + cv_q.size() + ncr_q.size() + ncw_q.size() + dn_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_strobes: left coh=%0d cv=%0d ncr=%0d ncw=%0d done=%0d, expected all 0",
               coh_q.size(), cv_q.size(), ncr_q.size(), ncw_q.size(), dn_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
